// File: rtl/guitar_input_conditioner_pkg.sv
// Shared constants for the guitar input conditioner: debounce defaults,
// lane count, event-FSM encoding and the saturating drop counter helper.
package guitar_input_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_W           = 20;
  localparam int LANES                   = 4;
  localparam int DROP_W                  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } evt_state_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/guitar_input_conditioner_debounce_bit.sv
// One contact: 2-flop synchronizer followed by a counter-based debouncer.
// settle is high on the cycle the stable value is about to flip.
module debounce_bit
  import guitar_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
)(
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic settle
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0, sync_p1;
  logic [CNT_W-1:0] cnt, cnt_next;

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive samples to flip.
  always_comb begin
    settle   = 1'b0;
    cnt_next = '0;
    if (sync_p1 != stable) begin
      if (cnt == LAST) settle   = 1'b1;
      else             cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      stable  <= stable ^ settle;
      cnt     <= cnt_next;
    end
  end

endmodule

// File: rtl/guitar_input_conditioner.sv
// Debounces the strum bar and four fret lanes, latches the fret chord on each
// debounced strum rise, and holds it as a pending event until acknowledged.
module guitar_input_conditioner
  import guitar_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              strum_raw,
  input  logic [LANES-1:0]  frets_raw,
  input  logic              strum_ack,
  output logic              new_strum,
  output logic              old_strum,
  output logic [LANES-1:0]  buttons,
  output logic              strum_valid,
  output logic [DROP_W-1:0] drop_count
);

  logic              strum_settle, strum_rise;
  logic [LANES-1:0]  fret_stable, fret_settle, fret_next;
  evt_state_t        state, state_next;
  logic [LANES-1:0]  buttons_next;
  logic [DROP_W-1:0] drop_next;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_strum (
    .clock  (clock),
    .reset  (reset),
    .raw    (strum_raw),
    .stable (new_strum),
    .settle (strum_settle)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_fret
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_fret (
      .clock  (clock),
      .reset  (reset),
      .raw    (frets_raw[i]),
      .stable (fret_stable[i]),
      .settle (fret_settle[i])
    );
  end

  // Edge taken from the settle pulse so the event lands on the same clock that
  // new_strum rises; the chord is sampled from the frets' next stable values.
  assign fret_next  = fret_stable ^ fret_settle;
  assign strum_rise = strum_settle & ~new_strum;

  always_comb begin
    state_next   = state;
    buttons_next = buttons;
    drop_next    = drop_count;
    unique case (state)
      IDLE: begin
        if (strum_rise) begin
          state_next   = PEND;
          buttons_next = fret_next;
        end
      end
      PEND: begin
        if (strum_rise && strum_ack) begin
          buttons_next = fret_next;
        end else if (strum_rise) begin
          drop_next = sat_inc(drop_count);
        end else if (strum_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      old_strum  <= 1'b0;
      buttons    <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_next;
      old_strum  <= new_strum;
      buttons    <= buttons_next;
      drop_count <= drop_next;
    end
  end

  assign strum_valid = (state == PEND);

endmodule

// File: tb/tb_guitar_input_conditioner.sv
// Directed bench for guitar_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_guitar_input_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic       strum_raw;
  logic [3:0] frets_raw;
  logic       strum_ack;
  logic       new_strum, old_strum, strum_valid;
  logic [3:0] buttons;
  logic [7:0] drop_count;

  int passed = 0;
  int total  = 0;

  guitar_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .strum_raw   (strum_raw),
    .frets_raw   (frets_raw),
    .strum_ack   (strum_ack),
    .new_strum   (new_strum),
    .old_strum   (old_strum),
    .buttons     (buttons),
    .strum_valid (strum_valid),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  // Advance n cycles; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic strum_cycle();
    strum_raw = 1'b0;
    tick(7);
    strum_raw = 1'b1;
    tick(7);
  endtask

  task automatic test_reset();
    reset = 1'b1; strum_raw = 1'b1; frets_raw = 4'b1111; strum_ack = 1'b0;
    tick(3);
    total++;
    if ({new_strum, old_strum, strum_valid, buttons, drop_count} !== 15'd0)
      $display("FAIL reset_outputs: got new=%b old=%b valid=%b buttons=%b drop=%0d, want all 0",
               new_strum, old_strum, strum_valid, buttons, drop_count);
    else passed++;
    strum_raw = 1'b0; frets_raw = 4'b0000;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_clean_strum();
    frets_raw = 4'b0101;
    tick(10);
    strum_raw = 1'b1;
    tick(5);
    total++;
    if (new_strum !== 1'b0 || strum_valid !== 1'b0)
      $display("FAIL clean_early: got new=%b valid=%b one cycle before latency, want 0 0", new_strum, strum_valid);
    else passed++;
    tick(1);
    total++;
    if (new_strum !== 1'b1 || old_strum !== 1'b0)
      $display("FAIL clean_edge: got new=%b old=%b, want 1 0", new_strum, old_strum);
    else passed++;
    total++;
    if (strum_valid !== 1'b1 || buttons !== 4'b0101)
      $display("FAIL clean_capture: got valid=%b buttons=%b, want 1 0101", strum_valid, buttons);
    else passed++;
    tick(1);
    total++;
    if (old_strum !== 1'b1)
      $display("FAIL clean_pulse_width: got old=%b, want 1", old_strum);
    else passed++;
  endtask

  task automatic test_handshake();
    strum_ack = 1'b1;
    tick(1);
    strum_ack = 1'b0;
    total++;
    if (strum_valid !== 1'b0 || buttons !== 4'b0101 || drop_count !== 8'd0)
      $display("FAIL handshake: got valid=%b buttons=%b drop=%0d, want 0 0101 0", strum_valid, buttons, drop_count);
    else passed++;
    strum_ack = 1'b1;
    tick(2);
    strum_ack = 1'b0;
    total++;
    if (strum_valid !== 1'b0)
      $display("FAIL ack_in_idle: got valid=%b, want 0", strum_valid);
    else passed++;
  endtask

  task automatic test_bounce();
    int rises;
    int first_rise;
    strum_raw = 1'b0;
    tick(8);
    total++;
    if (new_strum !== 1'b0 || strum_valid !== 1'b0)
      $display("FAIL release: got new=%b valid=%b, want 0 0", new_strum, strum_valid);
    else passed++;
    frets_raw = 4'b0011;
    tick(8);
    rises = 0;
    first_rise = -1;
    strum_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 3) strum_raw = 1'b0;
      if (k == 4) strum_raw = 1'b1;
      if (new_strum && !old_strum) begin
        rises++;
        if (first_rise < 0) first_rise = k;
      end
    end
    total++;
    if (rises !== 1 || first_rise !== 10)
      $display("FAIL bounce_events: got %0d rises first at +%0d, want 1 at +10", rises, first_rise);
    else passed++;
    total++;
    if (strum_valid !== 1'b1 || buttons !== 4'b0011)
      $display("FAIL bounce_capture: got valid=%b buttons=%b, want 1 0011", strum_valid, buttons);
    else passed++;
    strum_ack = 1'b1;
    tick(1);
    strum_ack = 1'b0;
  endtask

  task automatic test_drop_and_simultaneous();
    frets_raw = 4'b0110;
    tick(8);
    strum_cycle();
    total++;
    if (strum_valid !== 1'b1 || buttons !== 4'b0110 || drop_count !== 8'd0)
      $display("FAIL first_pending: got valid=%b buttons=%b drop=%0d, want 1 0110 0", strum_valid, buttons, drop_count);
    else passed++;
    frets_raw = 4'b1111;
    tick(8);
    total++;
    if (buttons !== 4'b0110)
      $display("FAIL fret_change_hold: got buttons=%b, want 0110", buttons);
    else passed++;
    strum_cycle();
    total++;
    if (strum_valid !== 1'b1 || buttons !== 4'b0110 || drop_count !== 8'd1)
      $display("FAIL drop_one: got valid=%b buttons=%b drop=%0d, want 1 0110 1", strum_valid, buttons, drop_count);
    else passed++;

    frets_raw = 4'b1000;
    tick(8);
    strum_raw = 1'b0;
    tick(7);
    strum_raw = 1'b1;
    tick(5);
    strum_ack = 1'b1;
    tick(1);
    strum_ack = 1'b0;
    total++;
    if (new_strum !== 1'b1 || old_strum !== 1'b0)
      $display("FAIL simul_edge: got new=%b old=%b, want 1 0", new_strum, old_strum);
    else passed++;
    total++;
    if (strum_valid !== 1'b1 || buttons !== 4'b1000 || drop_count !== 8'd1)
      $display("FAIL simul_accept: got valid=%b buttons=%b drop=%0d, want 1 1000 1", strum_valid, buttons, drop_count);
    else passed++;
    tick(1);
    total++;
    if (strum_valid !== 1'b1)
      $display("FAIL simul_stays_pending: got valid=%b, want 1", strum_valid);
    else passed++;

    repeat (300) strum_cycle();
    total++;
    if (drop_count !== 8'd255 || buttons !== 4'b1000 || strum_valid !== 1'b1)
      $display("FAIL drop_saturate: got drop=%0d buttons=%b valid=%b, want 255 1000 1", drop_count, buttons, strum_valid);
    else passed++;
  endtask

  task automatic test_reset_in_pend();
    reset = 1'b1; strum_raw = 1'b0; frets_raw = 4'b0101; strum_ack = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(10);
    strum_raw = 1'b1;
    tick(6);
    total++;
    if (strum_valid !== 1'b1 || buttons !== 4'b0101)
      $display("FAIL pend_before_reset: got valid=%b buttons=%b, want 1 0101", strum_valid, buttons);
    else passed++;
    tick(4);
    reset = 1'b1;
    tick(1);
    total++;
    if ({new_strum, strum_valid, buttons, drop_count} !== 14'd0)
      $display("FAIL reset_in_pend: got new=%b valid=%b buttons=%b drop=%0d, want all 0",
               new_strum, strum_valid, buttons, drop_count);
    else passed++;
    tick(1);
    reset = 1'b0;
    tick(5);
    total++;
    if (strum_valid !== 1'b0 || new_strum !== 1'b0)
      $display("FAIL post_reset_early: got valid=%b new=%b, want 0 0", strum_valid, new_strum);
    else passed++;
    tick(1);
    total++;
    if (strum_valid !== 1'b1 || new_strum !== 1'b1 || buttons !== 4'b0101)
      $display("FAIL post_reset_event: got valid=%b new=%b buttons=%b, want 1 1 0101", strum_valid, new_strum, buttons);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_strum();
    test_handshake();
    test_bounce();
    test_drop_and_simultaneous();
    test_reset_in_pend();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/guitar_input_conditioner.md
GUITAR_INPUT_CONDITIONER -- requirements
Module: guitar_input_conditioner

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the stability window: 10 ms at 50 MHz.
REQ-003 Parameter CNT_W, default 20, SHALL set the debounce counter width; DEBOUNCE_CYCLES SHALL fit in CNT_W bits.
REQ-004 Port clock, input, 1 bit: the system clock.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port strum_raw, input, 1 bit: the asynchronous strum-bar contact, active-high.
REQ-007 Port frets_raw, input, 4 bits: the asynchronous fret-button contacts, active-high; bit i is lane i.
REQ-008 Port strum_ack, input, 1 bit: the consumer has taken the current strum event.
REQ-009 Port new_strum, output, 1 bit: the debounced strum level.
REQ-010 Port old_strum, output, 1 bit: new_strum delayed by one clock.
REQ-011 Port buttons, output, 4 bits: the debounced fret state captured at the strum edge.
REQ-012 Port strum_valid, output, 1 bit: a strum event is pending.
REQ-013 Port drop_count, output, 8 bits: a saturating count of strum events lost while pending.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each of the 5 synchronized inputs SHALL have its own debouncer, built from a stable register and a counter.
REQ-016 Debouncer rule: if the synchronized input equals the stable value, the counter SHALL clear to 0.
REQ-017 Otherwise the counter SHALL increment; when it reaches DEBOUNCE_CYCLES-1, the stable value SHALL take the synchronized input and the counter SHALL clear.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change a stable value.
REQ-019 new_strum SHALL equal the strum debouncer's stable value.
REQ-020 old_strum SHALL be new_strum registered once, so new_strum & ~old_strum is high for exactly one cycle per debounced rising edge.
REQ-021 Latency from a clean strum_raw rise to new_strum high SHALL be exactly 2 + DEBOUNCE_CYCLES clocks.
REQ-022 The event FSM SHALL have two states, IDLE and PEND; strum_valid SHALL be 1 only in PEND.
REQ-023 IDLE to PEND: on the cycle a debounced rising edge is detected, buttons SHALL capture the debounced fret values.
REQ-024 PEND with strum_ack=1 and no new edge: the FSM SHALL return to IDLE, and buttons SHALL hold its last value.
REQ-025 PEND with a new edge and strum_ack=0: the FSM SHALL stay in PEND, buttons SHALL be unchanged, and drop_count SHALL increment, saturating at 255.
REQ-026 PEND with a new edge and strum_ack=1 on the same cycle: the new event SHALL be accepted, buttons SHALL recapture, the FSM SHALL stay in PEND, and drop_count SHALL be unchanged.
REQ-027 strum_ack SHALL be ignored in IDLE.
REQ-028 Fret changes SHALL never alter buttons except at a capture.

Reset
REQ-029 On reset, synchronizer flops, stable values and counters SHALL clear to 0.
REQ-030 On reset, new_strum, old_strum, buttons, strum_valid and drop_count SHALL clear to 0, and the FSM SHALL enter IDLE.
REQ-031 Reset asserted mid-debounce or in PEND SHALL abandon the event with no strum_valid pulse.
REQ-032 After reset, a strum held high SHALL produce one event, DEBOUNCE_CYCLES+2 cycles later.

Structure
REQ-033 The default DEBOUNCE_CYCLES and the IDLE/PEND state encodings SHALL live in a shared controller constants include used by the other control blocks.
REQ-034 One sub-module, debounce_bit (synchronizer plus debouncer for one bit, parameterized by DEBOUNCE_CYCLES and CNT_W), SHALL be instantiated 5 times.

Verification (DEBOUNCE_CYCLES=4 on the bench)
REQ-035 Clean strum: frets_raw=4'b0101 held, then strum_raw rises at cycle 10 -> new_strum=1 at cycle 16, one-cycle new&~old at cycle 16, strum_valid=1 at cycle 16, buttons=4'b0101.
REQ-036 Bounce: strum_raw toggles high for 3 cycles, low for 1, then high steady -> exactly one event; new_strum never rises during the 3-cycle pulse.
REQ-037 Handshake: with strum_valid=1, pulse strum_ack for 1 cycle -> strum_valid=0 next cycle, buttons held, drop_count=0.
REQ-038 Drop: a second debounced rising edge while pending without ack -> drop_count=1, buttons unchanged; repeated 300 times -> drop_count=255.
REQ-039 Simultaneous: strum_ack=1 on the same cycle as a new edge with frets=4'b1000 -> strum_valid stays 1, buttons=4'b1000, drop_count unchanged.
REQ-040 Reset in PEND at cycle 20 -> at cycle 21 strum_valid=0, buttons=0, drop_count=0, new_strum=0.
